// File: rtl/armleocpu_decode_queue.sv
// rtl/armleocpu_decode_queue.sv - decode queue between fetch and execute
// In-order instruction buffer with per-entry register-read pre-decode and redirect forwarding.
module armleocpu_decode_queue #(
   parameter int DEPTH      = 2,
   parameter int REG_ADDR_W = 5
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         f2d_instr_valid,
   input  logic [31:0]                  f2d_instr,
   input  logic [31:0]                  f2d_pc,
   input  logic [1:0]                   f2d_fetch_error,
   output logic                         d2f_ready,
   output logic [1:0]                   d2f_cmd,
   output logic [31:0]                  d2f_branchtarget,
   output logic                         d2e_valid,
   output logic [31:0]                  d2e_instr,
   output logic [31:0]                  d2e_pc,
   output logic [1:0]                   d2e_fetch_error,
   output logic                         d2e_rs1_read,
   output logic                         d2e_rs2_read,
   output logic [REG_ADDR_W-1:0]        d2e_rs1_addr,
   output logic [REG_ADDR_W-1:0]        d2e_rs2_addr,
   input  logic                         e2d_ready,
   input  logic [1:0]                   e2d_cmd,
   input  logic [31:0]                  e2d_branchtarget,
   output logic [$clog2(DEPTH+1)-1:0]   d2e_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
   localparam logic [1:0] CMD_NONE   = 2'd0;
   localparam logic [1:0] CMD_BRANCH = 2'd1;
   localparam logic [1:0] CMD_FLUSH  = 2'd2;

   typedef enum logic {ST_RUN, ST_REDIRECT} state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [1:0]         cmd_q, cmd_d;
   logic [31:0]        target_q, target_d;

   logic [31:0]        instr_q [DEPTH];
   logic [31:0]        pc_q    [DEPTH];
   logic [1:0]         err_q   [DEPTH];
   logic               rs1_rd_q[DEPTH];
   logic               rs2_rd_q[DEPTH];

   logic               redirect_req;
   logic               push;
   logic               pop;
   logic               dec_rs1;
   logic               dec_rs2;

   // Reserved command encoding 3 is deliberately not a redirect.
   assign redirect_req = (state_q == ST_RUN) &&
                         ((e2d_cmd == CMD_BRANCH) || (e2d_cmd == CMD_FLUSH));
   assign d2f_ready    = (state_q == ST_RUN) && (count_q != FULL) && !redirect_req;
   assign d2e_valid    = (state_q == ST_RUN) && (count_q != '0);
   assign push         = f2d_instr_valid && d2f_ready;
   assign pop          = d2e_valid && e2d_ready;

   always_comb begin
      dec_rs1 = 1'b0;
      dec_rs2 = 1'b0;
      case (f2d_instr[6:0])
         7'b1100111: dec_rs1 = 1'b1;
         7'b1100011: begin dec_rs1 = 1'b1; dec_rs2 = 1'b1; end
         7'b0000011: dec_rs1 = 1'b1;
         7'b0100011: begin dec_rs1 = 1'b1; dec_rs2 = 1'b1; end
         7'b0010011: dec_rs1 = 1'b1;
         7'b0110011: begin dec_rs1 = 1'b1; dec_rs2 = 1'b1; end
         7'b0101111: begin dec_rs1 = 1'b1; dec_rs2 = 1'b1; end
         7'b1110011: dec_rs1 = (f2d_instr[14:12] == 3'd1) || (f2d_instr[14:12] == 3'd2) ||
                               (f2d_instr[14:12] == 3'd3);
         default: ;
      endcase
      if (f2d_fetch_error != 2'd0) begin
         dec_rs1 = 1'b0;
         dec_rs2 = 1'b0;
      end
   end

   always_comb begin
      state_d  = state_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      cmd_d    = cmd_q;
      target_d = target_q;
      if (state_q == ST_REDIRECT) begin
         cmd_d   = CMD_NONE;
         state_d = ST_RUN;
      end else if (redirect_req) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         cmd_d    = e2d_cmd;
         target_d = e2d_branchtarget;
         state_d  = ST_REDIRECT;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push && !pop)      count_d = count_q + CNT_W'(1);
         else if (pop && !push) count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_RUN;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         cmd_q    <= CMD_NONE;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         cmd_q    <= cmd_d;
         target_q <= target_d;
      end
   end

   // Payload storage needs no reset: it is only observed behind d2e_valid.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_q[wr_ptr_q]  <= f2d_instr;
         pc_q[wr_ptr_q]     <= f2d_pc;
         err_q[wr_ptr_q]    <= f2d_fetch_error;
         rs1_rd_q[wr_ptr_q] <= dec_rs1;
         rs2_rd_q[wr_ptr_q] <= dec_rs2;
      end
   end

   assign d2f_cmd          = cmd_q;
   assign d2f_branchtarget = target_q;
   assign d2e_instr        = instr_q[rd_ptr_q];
   assign d2e_pc           = pc_q[rd_ptr_q];
   assign d2e_fetch_error  = err_q[rd_ptr_q];
   assign d2e_rs1_read     = rs1_rd_q[rd_ptr_q];
   assign d2e_rs2_read     = rs2_rd_q[rd_ptr_q];
   assign d2e_rs1_addr     = REG_ADDR_W'(d2e_instr[19:15]);
   assign d2e_rs2_addr     = REG_ADDR_W'(d2e_instr[24:20]);
   assign d2e_count        = count_q;

endmodule

// File: tb/tb_armleocpu_decode_queue.sv
// tb/tb_armleocpu_decode_queue.sv - directed scoreboard bench for armleocpu_decode_queue
// A depth-2 instance covers directed cases; a depth-4 instance covers pointer wrap.
module tb_armleocpu_decode_queue;

   logic        clk;
   logic        rst_n;

   logic        f_valid, e_ready;
   logic [31:0] f_instr, f_pc, e_target;
   logic [1:0]  f_err, e_cmd;
   logic        ready, valid, rs1r, rs2r;
   logic [1:0]  cmd, err;
   logic [31:0] target, instr, pc;
   logic [4:0]  rs1a, rs2a;
   logic [1:0]  count;

   logic        f_valid4, e_ready4;
   logic [31:0] f_pc4;
   logic        ready4, valid4, rs1r4, rs2r4;
   logic [1:0]  cmd4, err4;
   logic [31:0] target4, instr4, pc4;
   logic [5:0]  rs1a4, rs2a4;
   logic [2:0]  count4;

   armleocpu_decode_queue #(.DEPTH(2), .REG_ADDR_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .f2d_instr_valid(f_valid), .f2d_instr(f_instr), .f2d_pc(f_pc), .f2d_fetch_error(f_err),
      .d2f_ready(ready), .d2f_cmd(cmd), .d2f_branchtarget(target),
      .d2e_valid(valid), .d2e_instr(instr), .d2e_pc(pc), .d2e_fetch_error(err),
      .d2e_rs1_read(rs1r), .d2e_rs2_read(rs2r), .d2e_rs1_addr(rs1a), .d2e_rs2_addr(rs2a),
      .e2d_ready(e_ready), .e2d_cmd(e_cmd), .e2d_branchtarget(e_target), .d2e_count(count)
   );

   armleocpu_decode_queue #(.DEPTH(4), .REG_ADDR_W(6)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .f2d_instr_valid(f_valid4), .f2d_instr(32'h00C58633), .f2d_pc(f_pc4), .f2d_fetch_error(2'd0),
      .d2f_ready(ready4), .d2f_cmd(cmd4), .d2f_branchtarget(target4),
      .d2e_valid(valid4), .d2e_instr(instr4), .d2e_pc(pc4), .d2e_fetch_error(err4),
      .d2e_rs1_read(rs1r4), .d2e_rs2_read(rs2r4), .d2e_rs1_addr(rs1a4), .d2e_rs2_addr(rs2a4),
      .e2d_ready(e_ready4), .e2d_cmd(2'd0), .e2d_branchtarget(32'd0), .d2e_count(count4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [1:0]  err;
      logic        r1;
      logic        r2;
   } ent_t;

   ent_t        sb[$];
   logic [31:0] sb4[$];
   int          m_cnt, m_cnt4;
   bit          m_redir;
   logic [1:0]  m_cmd;
   logic [31:0] m_tgt;
   int          errors, checks;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic ent_t mk(input logic [31:0] p, input logic [31:0] ins, input logic [1:0] e);
      ent_t x;
      logic [2:0] f3;
      x.pc = p; x.instr = ins; x.err = e; x.r1 = 1'b0; x.r2 = 1'b0;
      f3 = ins[14:12];
      case (ins[6:0])
         7'h67, 7'h03, 7'h13: x.r1 = 1'b1;
         7'h63, 7'h23, 7'h33, 7'h2F: begin x.r1 = 1'b1; x.r2 = 1'b1; end
         7'h73: x.r1 = (f3 >= 3'd1 && f3 <= 3'd3);
         default: ;
      endcase
      if (e != 2'd0) begin x.r1 = 1'b0; x.r2 = 1'b0; end
      return x;
   endfunction

   // One cycle of the depth-2 instance: inputs already driven at the negedge.
   task automatic cyc();
      bit cv, er, ev, push, pop;
      #1;
      cv = !m_redir && (e_cmd == 2'd1 || e_cmd == 2'd2);
      er = !m_redir && (m_cnt != 2) && !cv;
      ev = !m_redir && (m_cnt != 0);
      check("d2f_ready", ready, er);
      check("d2e_valid", valid, ev);
      check("d2e_count", count, m_cnt);
      check("d2f_cmd", cmd, m_cmd);
      if (m_cmd != 2'd0) check("d2f_branchtarget", target, m_tgt);
      if (ev) begin
         check("d2e_pc", pc, sb[0].pc);
         check("d2e_instr", instr, sb[0].instr);
         check("d2e_fetch_error", err, sb[0].err);
         check("d2e_rs1_read", rs1r, sb[0].r1);
         check("d2e_rs2_read", rs2r, sb[0].r2);
         check("d2e_rs1_addr", rs1a, sb[0].instr[19:15]);
         check("d2e_rs2_addr", rs2a, sb[0].instr[24:20]);
      end
      push = f_valid && er;
      pop  = ev && e_ready;
      if (m_redir) begin
         m_redir = 1'b0;
         m_cmd   = 2'd0;
      end else if (cv) begin
         sb.delete();
         m_cnt   = 0;
         m_redir = 1'b1;
         m_cmd   = e_cmd;
         m_tgt   = e_target;
      end else begin
         if (pop) begin void'(sb.pop_front()); m_cnt--; end
         if (push) begin sb.push_back(mk(f_pc, f_instr, f_err)); m_cnt++; end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_ready", ready, 1'b1);
      check("rst_valid", valid, 1'b0);
      check("rst_count", count, 2'd0);
      check("rst_cmd", cmd, 2'd0);
      check("rst_target", target, 32'd0);
      check("rst_count4", count4, 3'd0);
      sb.delete(); sb4.delete();
      m_cnt = 0; m_cnt4 = 0; m_redir = 1'b0; m_cmd = 2'd0; m_tgt = 32'd0;
      f_valid = 1'b0; e_ready = 1'b0; e_cmd = 2'd0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [31:0] p, input logic [31:0] ins,
                        input logic [1:0] e, input logic rdy, input logic [1:0] c);
      f_valid = v; f_pc = p; f_instr = ins; f_err = e; e_ready = rdy; e_cmd = c;
   endtask

   initial begin
      errors = 0; checks = 0;
      rst_n = 1'b0;
      f_valid = 0; f_instr = 0; f_pc = 0; f_err = 0; e_ready = 0; e_cmd = 0; e_target = 0;
      f_valid4 = 0; f_pc4 = 0; e_ready4 = 0;
      @(negedge clk);
      do_reset();

      // Fill to DEPTH, third instruction held off
      drive(1, 32'h100, 32'h00000013, 0, 0, 0); cyc();
      drive(1, 32'h104, 32'h00000013, 0, 0, 0); cyc();
      drive(1, 32'h108, 32'h00000013, 0, 0, 0); cyc();
      // Full with pop: no push this cycle, then push with no pop
      drive(1, 32'h108, 32'h00000013, 0, 1, 0); cyc();
      drive(1, 32'h108, 32'h00000013, 0, 0, 0); cyc();
      check("full_refill_count", count, 2'd2);
      drive(0, 32'h0, 32'h0, 0, 1, 0); cyc(); cyc(); cyc();

      // Decode
      drive(1, 32'h200, 32'h00B50533, 0, 0, 0); cyc();
      drive(0, 32'h0, 32'h0, 0, 0, 0);
      #1;
      check("add_rs1_read", rs1r, 1'b1);
      check("add_rs2_read", rs2r, 1'b1);
      check("add_rs1_addr", rs1a, 5'd10);
      check("add_rs2_addr", rs2a, 5'd11);
      cyc();
      drive(1, 32'h204, 32'h00000537, 0, 1, 0); cyc();
      drive(1, 32'h208, 32'h00B50533, 1, 1, 0); cyc();
      drive(1, 32'h20C, 32'h00302573, 0, 1, 0); cyc();
      drive(1, 32'h210, 32'h00005573, 0, 1, 0); cyc();
      drive(1, 32'h214, 32'h0085A023, 0, 1, 0); cyc();
      drive(0, 32'h0, 32'h0, 0, 1, 0); cyc(); cyc();

      // Redirect with two entries queued; e2d_cmd during REDIRECT is ignored
      drive(1, 32'h300, 32'h00000013, 0, 0, 0); cyc();
      drive(1, 32'h304, 32'h00000013, 0, 0, 0); cyc();
      e_target = 32'h8000_0040;
      drive(1, 32'h308, 32'h00000013, 0, 0, 1); cyc();
      drive(1, 32'h308, 32'h00000013, 0, 0, 2); cyc();
      check("redir_cmd", cmd, 2'd0);
      drive(1, 32'h308, 32'h00000013, 0, 0, 0); cyc();
      drive(0, 32'h0, 32'h0, 0, 1, 0); cyc();

      // Reserved command 3 behaves like NONE
      drive(1, 32'h400, 32'h00000013, 0, 0, 0); cyc();
      drive(0, 32'h0, 32'h0, 0, 0, 3); cyc();
      drive(1, 32'h404, 32'h00000013, 0, 0, 0); cyc();

      // Reset mid-stream with two entries
      drive(0, 32'h0, 32'h0, 0, 0, 0); #1;
      check("pre_reset_count", count, 2'd2);
      do_reset();

      // Reset during REDIRECT drops the redirect
      e_target = 32'h1234_5678;
      drive(1, 32'h500, 32'h00000013, 0, 0, 0); cyc();
      drive(0, 32'h0, 32'h0, 0, 0, 2); cyc();
      drive(0, 32'h0, 32'h0, 0, 0, 0);
      #1;
      check("flush_cmd", cmd, 2'd2);
      do_reset();

      // Depth-4 wrap stream
      begin
         int pushed, popped;
         pushed = 0; popped = 0;
         for (int i = 0; i < 200 && popped < 10; i++) begin
            bit er4, ev4;
            f_valid4 = (pushed < 10);
            f_pc4    = 32'h1000 + 32'(pushed * 4);
            e_ready4 = 1'($urandom_range(0, 1));
            #1;
            er4 = (m_cnt4 != 4);
            ev4 = (m_cnt4 != 0);
            check("w_ready", ready4, er4);
            check("w_valid", valid4, ev4);
            check("w_count", count4, m_cnt4);
            if (ev4) begin
               check("w_pc", pc4, sb4[0]);
               check("w_rs1_addr", rs1a4, 6'd11);
            end
            if (ev4 && e_ready4) begin void'(sb4.pop_front()); m_cnt4--; popped++; end
            if (f_valid4 && er4) begin sb4.push_back(f_pc4); m_cnt4++; pushed++; end
            @(negedge clk);
         end
         f_valid4 = 1'b0; e_ready4 = 1'b0;
         check("w_popped", popped, 10);
         check("w_pushed", pushed, 10);
         #1;
         check("w_final_count", count4, 3'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
